// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencing controller.
//   - default datapath widths
//   - feedback tap mask and the non-zero seed used in place of the lock-up seed
//   - controller state encoding and a small state decode helper
package lfsr_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT = 8;

  // x^4 + x^3 + 1: feedback is q[3] ^ q[2]
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  // All-zero is the LFSR lock-up state; this value is loaded instead
  localparam logic [3:0] SEED_FIX = 4'b0001;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StCapt  = 3'd3,
    StShift = 3'd4,
    StDone  = 3'd5
  } state_e;

  function automatic logic state_busy(input state_e s);
    return s != StIdle;
  endfunction

endpackage

// File: rtl/lfsr4_core.sv
// Fibonacci LFSR register with synchronous load and step enable.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset, clears q
//   load - load d into q (priority over en)
//   en   - advance the LFSR one step
//   d    - load value
//   q    - current register contents
// WIDTH must be at least 2.
module lfsr4_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic fb;

  // XOR of the tapped bits shifts in at the LSB
  assign fb = ^(q & TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= {q[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for the LFSR datapath.
// A start in IDLE latches seed/run_len, loads the core, steps it run_len times,
// captures the register and shifts the captured word out LSB-first.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset
//   start    - begin a sequence (sampled only in IDLE)
//   abort    - synchronous cancel back to IDLE, beats everything but reset
//   seed     - seed value, sampled with start
//   run_len  - number of LFSR steps before capture, sampled with start
//   busy     - high while not IDLE
//   OUT      - serial data bit
//   vaild    - OUT qualifier
//   done     - one-cycle pulse after the last serial bit
//   seed_fix - one-cycle pulse in LOAD when a zero seed was replaced
// All outputs are decoded from registered state only.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] run_len,
  output logic             busy,
  output logic             OUT,
  output logic             vaild,
  output logic             done,
  output logic             seed_fix
);

  localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SEED_SUB = WIDTH'(SEED_FIX);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             latch_req;
  logic             seed_zero;
  logic             core_load;
  logic             core_en;
  logic [WIDTH-1:0] core_d;
  logic [WIDTH-1:0] core_q;

  assign seed_zero = (seed_q == '0);
  assign core_d    = seed_zero ? SEED_SUB : seed_q;

  lfsr4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .en   (core_en),
    .d    (core_d),
    .q    (core_q)
  );

  // Next-state and datapath control. Abort forces IDLE and suppresses every
  // register update, so core and cap keep their contents.
  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    idx_d     = idx_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StLoad;
            latch_req = 1'b1;
          end
        end
        StLoad: begin
          core_load = 1'b1;
          cnt_d     = run_len_q;
          state_d   = (run_len_q != '0) ? StRun : StCapt;
        end
        StRun: begin
          core_en = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          // Leaving at 1 means the counter never wraps, even at max run_len
          if (cnt_q == CNT_W'(1)) begin
            state_d = StCapt;
          end
        end
        StCapt: begin
          cap_d   = core_q;
          idx_d   = '0;
          state_d = StShift;
        end
        StShift: begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cap_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_q    <= '0;
      run_len_q <= '0;
    end else if (latch_req) begin
      seed_q    <= seed;
      run_len_q <= run_len;
    end
  end

  assign busy     = state_busy(state_q);
  assign vaild    = (state_q == StShift);
  assign OUT      = (state_q == StShift) ? cap_q[idx_q] : 1'b0;
  assign done     = (state_q == StDone);
  assign seed_fix = (state_q == StLoad) && seed_zero;

endmodule
